pio_avalon_arbiter: RTL and testbench
=====================================

Name: pio_avalon_arbiter

Overview:
- Two-master arbiter sharing one Avalon-MM PIO slave port (2-bit address, chipselect, write_n, 32-bit writedata, combinational readdata), e.g. the CPU and the SDRAM test engine both driving the LED/status PIO.
- Adds waitrequest to each master side, serialises accesses, and arbitrates round-robin.
- Sits between the masters and the PIO slave; the PIO's own interface is unchanged.

Parameters:
- DATA_W, 32, data width of writedata/readdata on all ports.
- ADDR_W, 2, word address width on all ports.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_chipselect  in  1  master 0 request
- m0_write_n  in  1  master 0 write strobe, 0 = write, 1 = read
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data, valid when m0_waitrequest=0
- m0_waitrequest  out  1  master 0 stall
- m1_address, m1_chipselect, m1_write_n, m1_writedata, m1_readdata, m1_waitrequest: same as m0_* for master 1
- s_address  out  ADDR_W  to PIO slave
- s_chipselect  out  1  to PIO slave
- s_write_n  out  1  to PIO slave
- s_writedata  out  DATA_W  to PIO slave
- s_readdata  in  DATA_W  from PIO slave, combinational on s_address
- grant  out  2  one-hot owner of the current transfer, 00 when IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (master 0 wins the first tie), grant=00.
  - s_chipselect=0, s_write_n=1, s_address=0, s_writedata=0.
  - m0/m1_waitrequest=1, m0/m1_readdata=0.
- Reset asserted mid-transfer aborts it with no slave access. Masters must re-issue.
- FSM, all registered:
  - IDLE: sample m0_chipselect/m1_chipselect.
    - One requester: grant it.
    - Both requesting: grant ~last_grant.
    - On grant, latch that master's address/write_n/writedata into s_* and set s_chipselect=1. Go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE: s_* held exactly one cycle. The PIO performs the write at the end of this cycle. Capture s_readdata into the granted master's readdata register. Go to DONE.
  - DONE: s_chipselect=0, s_write_n=1. The granted master's waitrequest=0 for exactly this cycle, so the transfer completes. Update last_grant to the granted master. Go to IDLE.
- mK_waitrequest = NOT(state==DONE AND grant==K). It is high in IDLE and ISSUE whether or not chipselect is asserted.
- Latency: request seen in IDLE at cycle N, slave access at N+1, master completes at N+2. Peak throughput is one transfer per 3 cycles.
- Masters hold all request signals while waitrequest=1 (Avalon rule). Signals are latched at IDLE->ISSUE, so later changes do not affect the in-flight transfer.
- Write transfers also return captured s_readdata. Masters ignore it.
- The non-granted master's readdata register holds its previous value.
- grant is valid in ISSUE and DONE and is 00 in IDLE.
- Back-to-back: a master may re-assert chipselect in the cycle after DONE. The round-robin then favours the other master if it is requesting.
- Requesting master with a silent peer: served every 3 cycles with no penalty.

Optional Feature:
- Macro: PIO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Master 0 always wins when both request; last_grant is unused and may be removed. Master 1 may starve while master 0 requests continuously.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset: hold reset=1, then release -> s_chipselect=0, s_write_n=1, both waitrequest=1, grant=00, m0/m1_readdata=0.
- Single write: m0 writes 0x00000001 to address 0 at cycle N.
  - Cycle N+1: s_chipselect=1, s_write_n=0, s_writedata=0x1, grant=01.
  - Cycle N+2: m0_waitrequest=0.
  - PIO out_port=1 after N+2.
- Read-back: m1 reads address 0 after the write above -> m1_waitrequest low at N+2 with m1_readdata=0x00000001. m1 reads address 1 -> m1_readdata=0.
- Simultaneous: m0 and m1 request continuously from reset (m0 writes 0xA, m1 writes 0x5) -> grants alternate 01,10,01,10 on successive transfers, each master completes every 6 cycles. With PIO_ARB_FIXED_PRIO_EN defined -> grant stays 01 and m1_waitrequest never falls.
- Reset mid-transfer: assert reset during ISSUE for an m1 write of 0x1 -> s_chipselect drops immediately, state=IDLE, m1_waitrequest=1. After release, m1's held request completes normally within 3 cycles.
- Late signal change: m0 changes writedata from 0x1 to 0x0 during ISSUE -> the slave receives 0x1 and the PIO holds 1.

Source files
------------

// File: rtl/pio_avalon_arbiter_if.sv
// Avalon-MM PIO-style bus bundle: 2-bit word address, chipselect, write_n, writedata, combinational readdata.
// The slave side of the arbiter adds waitrequest; the pio_master view omits it because the PIO has none.
interface pio_avalon_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, waitrequest
    );

    modport pio_master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );
endinterface

// File: rtl/pio_avalon_arbiter.sv
// Two-master arbiter in front of one Avalon-MM PIO slave: IDLE -> ISSUE -> DONE, round-robin on ties.
// Define PIO_ARB_FIXED_PRIO_EN for fixed priority (master 0 always wins a tie).
module pio_avalon_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_avalon_arbiter_if.slave      m0,
    pio_avalon_arbiter_if.slave      m1,
    pio_avalon_arbiter_if.pio_master s,
    output logic [1:0]           grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_grant;
    logic [ADDR_W-1:0]   r_s_address;
    logic                r_s_chipselect;
    logic                r_s_write_n;
    logic [DATA_W-1:0]   r_s_writedata;
    logic [DATA_W-1:0]   r_m0_readdata;
    logic [DATA_W-1:0]   r_m1_readdata;
    logic                r_m0_waitrequest;
    logic                r_m1_waitrequest;
`ifndef PIO_ARB_FIXED_PRIO_EN
    logic                r_last_grant;
`endif

    logic                w_any_req;
    logic                w_pick_m1;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_any_req = m0.chipselect | m1.chipselect;
`ifdef PIO_ARB_FIXED_PRIO_EN
        w_pick_m1 = m1.chipselect & ~m0.chipselect;
`else
        // r_last_grant = 1 means master 1 went last, so master 0 wins the next tie.
        w_pick_m1 = m1.chipselect & (~m0.chipselect | ~r_last_grant);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the data registers are
    // reset as well so masters never observe X on readdata after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_grant          <= 2'b00;
            r_s_address      <= '0;
            r_s_chipselect   <= 1'b0;
            r_s_write_n      <= 1'b1;
            r_s_writedata    <= '0;
            r_m0_readdata    <= '0;
            r_m1_readdata    <= '0;
            r_m0_waitrequest <= 1'b1;
            r_m1_waitrequest <= 1'b1;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_last_grant     <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant        <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_s_address    <= w_pick_m1 ? m1.address   : m0.address;
                        r_s_write_n    <= w_pick_m1 ? m1.write_n   : m0.write_n;
                        r_s_writedata  <= w_pick_m1 ? m1.writedata : m0.writedata;
                        r_s_chipselect <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_grant[1]) begin
                        r_m1_readdata <= s.readdata;
                    end else begin
                        r_m0_readdata <= s.readdata;
                    end
                    r_s_chipselect   <= 1'b0;
                    r_s_write_n      <= 1'b1;
                    r_m0_waitrequest <= ~r_grant[0];
                    r_m1_waitrequest <= ~r_grant[1];
                    r_state          <= S_DONE;
                end
                S_DONE: begin
                    r_m0_waitrequest <= 1'b1;
                    r_m1_waitrequest <= 1'b1;
`ifndef PIO_ARB_FIXED_PRIO_EN
                    r_last_grant     <= r_grant[1];
`endif
                    r_grant          <= 2'b00;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s.address      = r_s_address;
    assign s.chipselect   = r_s_chipselect;
    assign s.write_n      = r_s_write_n;
    assign s.writedata    = r_s_writedata;
    assign m0.readdata    = r_m0_readdata;
    assign m1.readdata    = r_m1_readdata;
    assign m0.waitrequest = r_m0_waitrequest;
    assign m1.waitrequest = r_m1_waitrequest;
    assign grant          = r_grant;

endmodule

// File: tb/tb_pio_avalon_arbiter.sv
// Directed bench for pio_avalon_arbiter with a behavioural PIO (address 0 = output register).
// Expected values are hand-derived; PIO_ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
module tb_pio_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  grant;
    logic [31:0] pio_reg = 32'h0;

    int vectors     = 0;
    int miscompares = 0;

    pio_avalon_arbiter_if #(.DATA_W(32), .ADDR_W(2)) m0_if ();
    pio_avalon_arbiter_if #(.DATA_W(32), .ADDR_W(2)) m1_if ();
    pio_avalon_arbiter_if #(.DATA_W(32), .ADDR_W(2)) s_if ();

    pio_avalon_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    always #5 clk = ~clk;

    // PIO model: writes land at the clock edge that ends the chipselect cycle; reads are combinational.
    always @(posedge clk) begin
        if (s_if.chipselect && !s_if.write_n && s_if.address == 2'd0) pio_reg <= s_if.writedata;
    end
    assign s_if.readdata    = (s_if.address == 2'd0) ? pio_reg : 32'h0;
    assign s_if.waitrequest = 1'b0;

    task automatic drive_master(input int m, input logic cs, input logic [1:0] a, input logic wn,
                                input logic [31:0] d);
        if (m == 0) begin
            m0_if.chipselect = cs; m0_if.address = a; m0_if.write_n = wn; m0_if.writedata = d;
        end else begin
            m1_if.chipselect = cs; m1_if.address = a; m1_if.write_n = wn; m1_if.writedata = d;
        end
    endtask

    // Issues one transfer from IDLE and waits (bounded) for completion; lat = cycles to completion or -1.
    task automatic do_xfer(input int m, input logic [1:0] a, input logic wn, input logic [31:0] d,
                           output int lat);
        @(negedge clk);
        drive_master(m, 1'b1, a, wn, d);
        lat = -1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if ((m == 0) ? !m0_if.waitrequest : !m1_if.waitrequest) lat = c;
        end
        drive_master(m, 1'b0, a, 1'b1, d);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (s_if.chipselect !== 1'b0) begin miscompares++; $display("FAIL reset_s_cs: got %b expected 0", s_if.chipselect); end
        vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_m0_wait: got %b expected 1", m0_if.waitrequest); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (s_if.chipselect !== 1'b0) begin miscompares++; $display("FAIL rel_s_cs: got %b expected 0", s_if.chipselect); end
        vectors++; if (s_if.write_n !== 1'b1) begin miscompares++; $display("FAIL rel_s_wn: got %b expected 1", s_if.write_n); end
        vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL rel_m0_wait: got %b expected 1", m0_if.waitrequest); end
        vectors++; if (m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL rel_m1_wait: got %b expected 1", m1_if.waitrequest); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rel_grant: got %b expected 00", grant); end
        vectors++; if (m0_if.readdata !== 32'h0) begin miscompares++; $display("FAIL rel_m0_rd: got %h expected 0", m0_if.readdata); end
        vectors++; if (m1_if.readdata !== 32'h0) begin miscompares++; $display("FAIL rel_m1_rd: got %h expected 0", m1_if.readdata); end
    endtask

    task automatic test_single_write;
        @(negedge clk);
        drive_master(0, 1'b1, 2'd0, 1'b0, 32'h1);
        @(posedge clk); @(negedge clk);  // ISSUE
        vectors++; if (s_if.chipselect !== 1'b1) begin miscompares++; $display("FAIL wr_s_cs: got %b expected 1", s_if.chipselect); end
        vectors++; if (s_if.write_n !== 1'b0) begin miscompares++; $display("FAIL wr_s_wn: got %b expected 0", s_if.write_n); end
        vectors++; if (s_if.writedata !== 32'h1) begin miscompares++; $display("FAIL wr_s_wd: got %h expected 1", s_if.writedata); end
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL wr_grant_issue: got %b expected 01", grant); end
        vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_m0_wait_issue: got %b expected 1", m0_if.waitrequest); end
        @(posedge clk); @(negedge clk);  // DONE
        vectors++; if (m0_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL wr_m0_wait_done: got %b expected 0", m0_if.waitrequest); end
        vectors++; if (m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_m1_wait_done: got %b expected 1", m1_if.waitrequest); end
        vectors++; if (s_if.chipselect !== 1'b0) begin miscompares++; $display("FAIL wr_s_cs_done: got %b expected 0", s_if.chipselect); end
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL wr_grant_done: got %b expected 01", grant); end
        vectors++; if (pio_reg !== 32'h1) begin miscompares++; $display("FAIL wr_pio: got %h expected 1", pio_reg); end
        vectors++; if (m0_if.readdata !== 32'h0) begin miscompares++; $display("FAIL wr_m0_rd: got %h expected 0", m0_if.readdata); end
        drive_master(0, 1'b0, 2'd0, 1'b1, 32'h1);
        @(posedge clk); @(negedge clk);  // IDLE
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL wr_grant_idle: got %b expected 00", grant); end
        vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL wr_m0_wait_idle: got %b expected 1", m0_if.waitrequest); end
    endtask

    task automatic test_read_back;
        int lat;
        do_xfer(1, 2'd0, 1'b1, 32'h0, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd0_latency: got %0d expected 2", lat); end
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rd0_grant: got %b expected 10", grant); end
        vectors++; if (m1_if.readdata !== 32'h1) begin miscompares++; $display("FAIL rd0_m1_rd: got %h expected 1", m1_if.readdata); end
        vectors++; if (m0_if.readdata !== 32'h0) begin miscompares++; $display("FAIL rd0_m0_hold: got %h expected 0", m0_if.readdata); end
        do_xfer(1, 2'd1, 1'b1, 32'h0, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd1_latency: got %0d expected 2", lat); end
        vectors++; if (m1_if.readdata !== 32'h0) begin miscompares++; $display("FAIL rd1_m1_rd: got %h expected 0", m1_if.readdata); end
    endtask

    // Both masters request continuously from reset release; completions expected at cycles 2, 5, 8, 11.
    task automatic test_simultaneous;
        int          n_done;
        logic        m1_fell;
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        n_done  = 0;
        m1_fell = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive_master(0, 1'b1, 2'd0, 1'b0, 32'hA);
        drive_master(1, 1'b1, 2'd0, 1'b0, 32'h5);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 20 && n_done < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (!m1_if.waitrequest) m1_fell = 1'b1;
            if (!m0_if.waitrequest || !m1_if.waitrequest) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
                exp_g = 2'b01;
`else
                exp_g = (n_done % 2 == 0) ? 2'b01 : 2'b10;
`endif
                exp_d = (exp_g == 2'b01) ? 32'hA : 32'h5;
                vectors++; if (c !== 2 + 3 * n_done) begin miscompares++; $display("FAIL sim_cycle%0d: got %0d expected %0d", n_done, c, 2 + 3 * n_done); end
                vectors++; if (grant !== exp_g) begin miscompares++; $display("FAIL sim_grant%0d: got %b expected %b", n_done, grant, exp_g); end
                vectors++; if ({m1_if.waitrequest, m0_if.waitrequest} !== ~exp_g) begin miscompares++; $display("FAIL sim_wait%0d: got %b expected %b", n_done, {m1_if.waitrequest, m0_if.waitrequest}, ~exp_g); end
                vectors++; if (pio_reg !== exp_d) begin miscompares++; $display("FAIL sim_pio%0d: got %h expected %h", n_done, pio_reg, exp_d); end
                n_done++;
            end
        end
        vectors++; if (n_done !== 4) begin miscompares++; $display("FAIL sim_timeout: got %0d completions expected 4", n_done); end
`ifdef PIO_ARB_FIXED_PRIO_EN
        vectors++; if (m1_fell !== 1'b0) begin miscompares++; $display("FAIL sim_m1_starve: got %b expected 0", m1_fell); end
`endif
        drive_master(0, 1'b0, 2'd0, 1'b1, 32'h0);
        drive_master(1, 1'b0, 2'd0, 1'b1, 32'h0);
        @(posedge clk);  // DONE -> IDLE
    endtask

    // A lone master holding chipselect is served every 3 cycles.
    task automatic test_back_to_back;
        int n_done;
        n_done = 0;
        @(negedge clk);
        drive_master(0, 1'b1, 2'd1, 1'b1, 32'h0);
        for (int c = 1; c <= 12 && n_done < 3; c++) begin
            @(posedge clk); @(negedge clk);
            if (!m0_if.waitrequest) begin
                vectors++; if (c !== 2 + 3 * n_done) begin miscompares++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", n_done, c, 2 + 3 * n_done); end
                n_done++;
            end
        end
        vectors++; if (n_done !== 3) begin miscompares++; $display("FAIL b2b_timeout: got %0d completions expected 3", n_done); end
        drive_master(0, 1'b0, 2'd0, 1'b1, 32'h0);
        @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        do_xfer(0, 2'd0, 1'b0, 32'h2, lat);
        vectors++; if (pio_reg !== 32'h2) begin miscompares++; $display("FAIL mid_setup_pio: got %h expected 2", pio_reg); end
        @(negedge clk);
        drive_master(1, 1'b1, 2'd0, 1'b0, 32'h1);
        @(posedge clk); @(negedge clk);  // ISSUE
        vectors++; if (s_if.chipselect !== 1'b1) begin miscompares++; $display("FAIL mid_pre_cs: got %b expected 1", s_if.chipselect); end
        reset = 1'b1;
        #1;
        vectors++; if (s_if.chipselect !== 1'b0) begin miscompares++; $display("FAIL mid_s_cs: got %b expected 0", s_if.chipselect); end
        vectors++; if (m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL mid_m1_wait: got %b expected 1", m1_if.waitrequest); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL mid_grant: got %b expected 00", grant); end
        @(posedge clk); @(negedge clk);
        vectors++; if (pio_reg !== 32'h2) begin miscompares++; $display("FAIL mid_no_access: got %h expected 2", pio_reg); end
        reset = 1'b0;
        lat = -1;
        for (int c = 1; c <= 3 && lat < 0; c++) begin
            @(posedge clk); @(negedge clk);
            if (!m1_if.waitrequest) lat = c;
        end
        vectors++; if (lat < 0) begin miscompares++; $display("FAIL mid_retry_timeout: got %0d expected 1..3", lat); end
        vectors++; if (pio_reg !== 32'h1) begin miscompares++; $display("FAIL mid_retry_pio: got %h expected 1", pio_reg); end
        drive_master(1, 1'b0, 2'd0, 1'b1, 32'h0);
        @(posedge clk);
    endtask

    task automatic test_late_change;
        int lat;
        do_xfer(1, 2'd0, 1'b0, 32'h0, lat);
        vectors++; if (pio_reg !== 32'h0) begin miscompares++; $display("FAIL late_setup_pio: got %h expected 0", pio_reg); end
        @(negedge clk);
        drive_master(0, 1'b1, 2'd0, 1'b0, 32'h1);
        @(posedge clk); @(negedge clk);  // ISSUE
        m0_if.writedata = 32'h0;
        #1;
        vectors++; if (s_if.writedata !== 32'h1) begin miscompares++; $display("FAIL late_s_wd: got %h expected 1", s_if.writedata); end
        @(posedge clk); @(negedge clk);  // DONE
        vectors++; if (m0_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL late_m0_wait: got %b expected 0", m0_if.waitrequest); end
        vectors++; if (pio_reg !== 32'h1) begin miscompares++; $display("FAIL late_pio: got %h expected 1", pio_reg); end
        drive_master(0, 1'b0, 2'd0, 1'b1, 32'h0);
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive_master(0, 1'b0, 2'd0, 1'b1, 32'h0);
        drive_master(1, 1'b0, 2'd0, 1'b1, 32'h0);
        test_reset;
        test_single_write;
        test_read_back;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid;
        test_late_change;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
